mem_responder: RTL and testbench
================================

# mem_responder

- Memory-side responder for the accumulator CPU's bus; the CPU drives `MemRead`/`MemWrite` strobes with an address and write data.
- Sits between the CPU top and the unified instruction/data store.
- Samples one request at a time, inserts a programmable number of wait states, then performs the access and pulses `ready` for one cycle with read data.
- Lets the multicycle controller stall on real memory latency instead of assuming single-cycle memory.

## Interface
Parameters:
- `DATA_W`, 8, word width; instruction format is 3-bit opcode + 5-bit address.
- `ADDR_W`, 5, word address width; depth = 2**ADDR_W.
- `WAIT_CYCLES`, 2, wait states inserted before each access (0..15).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `MemRead`  in  1  read request strobe.
- `MemWrite`  in  1  write request strobe.
- `addr`  in  ADDR_W  word address, valid with a strobe.
- `wdata`  in  DATA_W  write data, valid with `MemWrite`.
- `rdata`  out  DATA_W  read data, valid while `ready`=1 after a read.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  request accepted and not yet completed.
- `err`  out  1  one-cycle pulse on an illegal request or a parity error.

## Operation
States: IDLE, WAIT, RESP.

- **IDLE:**
  - Samples strobes every cycle.
  - Exactly one of `MemRead`/`MemWrite` high: latch addr, wdata and type; load counter with WAIT_CYCLES; go to WAIT, or to RESP if WAIT_CYCLES=0.
  - Both high: request rejected, `err` pulses next cycle, stay IDLE, no access.
  - Neither high: stay IDLE.
- **WAIT:** decrement counter; at 1 go to RESP. Strobes and addr/wdata changes are ignored; latched values are used.
- **RESP:**
  - Write: array updated with the latched wdata at the latched addr on entry edge.
  - Read: `rdata` loaded from the array.
  - `ready`=1 for exactly this cycle, then always return to IDLE.
  - Strobes in RESP are ignored.
  - The CPU must drop or re-issue strobes after seeing `ready`. Strobes still high in the following IDLE cycle are a new request.
- `busy`=1 in WAIT and RESP, 0 in IDLE.
- `rdata` holds its last read value until the next read completes; it is not cleared by writes.
- Address wrap: addr is exactly ADDR_W bits, so there is no out-of-range case.
- Array contents are not cleared by `rst`. An initial image is loaded at elaboration by the bench or top.

## Timing
- Reset values: `ready`=0, `busy`=0, `err`=0, `rdata`=0, state IDLE, counter 0.
- Latency: request sampled at edge N, `ready` high during cycle N+WAIT_CYCLES+1. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Read-after-write to the same address, with the read issued in the IDLE cycle after the write's `ready`, returns the new data.
- Reset mid-operation (WAIT or RESP-entry edge coinciding with `rst`):
  - Reset wins, so the pending write is not committed and `ready` does not pulse.
  - State returns to IDLE.
- `err` for an illegal request: high in cycle N+1 only; `busy` stays 0.

## Configuration
- `MEM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit computed on write.
  - On a read in RESP, a mismatch pulses `err` together with `ready`. `rdata` still carries the stored word.
  - The bench can flip a stored parity bit through a hierarchical force.
- Undefined: no parity storage; `err` is driven only by illegal requests.

## Structure
- Shared package `mem_pkg`:
  - state enum (IDLE, WAIT, RESP);
  - default DATA_W/ADDR_W constants shared with the CPU datapath;
  - the counter width constant (4).
- Sub-module `mem_array`:
  - Storage only, synchronous write and combinational read, DATA_W(+1 under `MEM_PARITY_EN`) wide.
  - The FSM, counter and latches live in `mem_responder`.

## Test plan
- Read with WAIT_CYCLES=2: preload mem[5]=8'h3C, `MemRead` with addr=5 at edge 0 → `ready` and `rdata`=8'h3C in cycle 3, `busy` high in cycles 1–3.
- Write then read: write 8'hA7 to addr 31, then read addr 31 in the next IDLE cycle → `rdata`=8'hA7, addr 0 unchanged.
- WAIT_CYCLES=0: `MemRead` addr 2 → `ready` in the very next cycle; a held strobe produces a second `ready` 2 cycles later.
- Both strobes high → `err` pulses once, `busy`=0, no `ready`, memory unchanged.
- `rst` during WAIT of a write of 8'hFF to addr 9 → no `ready`, mem[9] keeps its old value, all outputs at reset values.
- `MEM_PARITY_EN`: corrupt the parity of mem[4], then read addr 4 → `ready` and `err` high in the same cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and the accumulator CPU datapath.
// MEM_PARITY_EN adds one even-parity bit to every stored word.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 5;
   localparam int CNT_W      = 4;

`ifdef MEM_PARITY_EN
   localparam int PARITY_W = 1;
`else
   localparam int PARITY_W = 0;
`endif

endpackage

// File: rtl/mem_responder_if.sv
// CPU-to-memory bus: request strobes, address and data toward memory,
// completion status and read data back.
interface mem_responder_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);

   logic              MemRead;
   logic              MemWrite;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              busy;
   logic              err;

   modport master (
      output MemRead, MemWrite, addr, wdata,
      input  rdata, ready, busy, err
   );

   modport slave (
      input  MemRead, MemWrite, addr, wdata,
      output rdata, ready, busy, err
   );

endinterface

// File: rtl/mem_array.sv
// Unified instruction/data storage: synchronous write, combinational read.
// Under MEM_PARITY_EN each word carries an extra parity bit in its MSB.
module mem_array
   import mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [ADDR_W-1:0]            addr,
   input  logic [DATA_W+PARITY_W-1:0]   wdata,
   output logic [DATA_W+PARITY_W-1:0]   rdata
);

   localparam int WORD_W = DATA_W + PARITY_W;
   localparam int DEPTH  = 1 << ADDR_W;

   // Contents survive reset; the initial image comes from outside.
   logic [WORD_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, WAIT_CYCLES wait states, then a
// one-cycle ready pulse. MEM_PARITY_EN enables stored parity and error reporting.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   mem_responder_if.slave  bus
);

   localparam int WORD_W = DATA_W + PARITY_W;
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              is_wr_q, is_wr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic              req_one;
   logic              req_both;
   logic              go_resp;
   logic              mem_we;
   logic              par_err;
   logic [WORD_W-1:0] mem_wword;
   logic [WORD_W-1:0] mem_rword;

   assign req_one  = bus.MemRead ^ bus.MemWrite;
   assign req_both = bus.MemRead & bus.MemWrite;

   // go_resp marks the edge that enters RESP; the access happens on that edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      is_wr_d = is_wr_q;
      go_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_one) begin
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               is_wr_d = bus.MemWrite;
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
                  cnt_d   = '0;
                  go_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = RESP;
               cnt_d   = '0;
               go_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef MEM_PARITY_EN
   assign mem_wword = {^wdata_d, wdata_d};
   assign par_err   = go_resp & ~is_wr_d & (^mem_rword);
`else
   assign mem_wword = wdata_d;
   assign par_err   = 1'b0;
`endif

   // A reset on the RESP-entry edge must suppress the pending write.
   always_comb begin
      mem_we  = go_resp & is_wr_d & ~rst;
      rdata_d = rdata_q;
      if (go_resp && !is_wr_d) begin
         rdata_d = mem_rword[DATA_W-1:0];
      end
      ready_d = go_resp;
      busy_d  = (state_d != IDLE);
      err_d   = ((state_q == IDLE) & req_both) | par_err;
   end

   mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (addr_d),
      .wdata (mem_wword),
      .rdata (mem_rword)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         is_wr_q <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         is_wr_q <= is_wr_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance
// sharing one clock, with a per-instance scoreboard of expected completions.
module tb_mem_responder;

   typedef struct {
      logic       is_read;
      logic [7:0] data;
      logic       err;
   } exp_t;

   logic clk;
   logic rst;

   int checks = 0;
   int errors = 0;

   exp_t       sb2[$];
   exp_t       sb0[$];
   logic [7:0] model2 [32];
   logic [7:0] model0 [32];

   mem_responder_if #(.DATA_W(8), .ADDR_W(5)) bus2 ();
   mem_responder_if #(.DATA_W(8), .ADDR_W(5)) bus0 ();

   mem_responder #(.DATA_W(8), .ADDR_W(5), .WAIT_CYCLES(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   mem_responder #(.DATA_W(8), .ADDR_W(5), .WAIT_CYCLES(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int sel, input logic rd, input logic wr,
                                input logic [4:0] a, input logic [7:0] d);
      if (sel == 0) begin
         bus0.MemRead  = rd;
         bus0.MemWrite = wr;
         bus0.addr     = a;
         bus0.wdata    = d;
      end else begin
         bus2.MemRead  = rd;
         bus2.MemWrite = wr;
         bus2.addr     = a;
         bus2.wdata    = d;
      end
   endtask

   function automatic logic ready_of(input int sel);
      return (sel == 0) ? bus0.ready : bus2.ready;
   endfunction

   function automatic logic busy_of(input int sel);
      return (sel == 0) ? bus0.busy : bus2.busy;
   endfunction

   // One full access from an IDLE negedge; leaves the bench in the next IDLE cycle.
   task automatic runAccess(input int sel, input logic is_wr, input logic [4:0] a,
                            input logic [7:0] d, input logic exp_err);
      exp_t e;
      int   lat_exp;
      int   lat;
      lat_exp   = (sel == 0) ? 1 : 3;
      lat       = 0;
      e.is_read = !is_wr;
      e.err     = exp_err;
      if (is_wr) begin
         e.data = d;
         if (sel == 0) model0[a] = d;
         else          model2[a] = d;
      end else begin
         e.data = (sel == 0) ? model0[a] : model2[a];
      end
      if (sel == 0) sb0.push_back(e);
      else          sb2.push_back(e);
      applyStimulus(sel, !is_wr, is_wr, a, d);
      @(posedge clk);
      #1;
      applyStimulus(sel, 1'b0, 1'b0, a, d);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checkOutput("busy_pending", {31'd0, busy_of(sel)}, 32'd1);
         if (ready_of(sel)) begin
            lat = k;
            break;
         end
      end
      checkOutput("latency", lat, lat_exp);
      @(negedge clk);
      checkOutput("busy_idle", {31'd0, busy_of(sel)}, 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && bus2.ready) begin
         if (sb2.size() == 0) begin
            checkOutput("sb2_unexpected_ready", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb2.pop_front();
            if (e.is_read) checkOutput("sb2_rdata", {24'd0, bus2.rdata}, {24'd0, e.data});
            checkOutput("sb2_err", {31'd0, bus2.err}, {31'd0, e.err});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bus0.ready) begin
         if (sb0.size() == 0) begin
            checkOutput("sb0_unexpected_ready", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb0.pop_front();
            if (e.is_read) checkOutput("sb0_rdata", {24'd0, bus0.rdata}, {24'd0, e.data});
            checkOutput("sb0_err", {31'd0, bus0.err}, {31'd0, e.err});
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] rnd [4];
      rst = 1'b1;
      applyStimulus(0, 1'b0, 1'b0, 5'd0, 8'd0);
      applyStimulus(2, 1'b0, 1'b0, 5'd0, 8'd0);
      repeat (3) @(negedge clk);
      checkOutput("rst_ready", {31'd0, bus2.ready}, 32'd0);
      checkOutput("rst_busy",  {31'd0, bus2.busy},  32'd0);
      checkOutput("rst_err",   {31'd0, bus2.err},   32'd0);
      checkOutput("rst_rdata", {24'd0, bus2.rdata}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Preload through the bus, then the basic read at WAIT_CYCLES=2.
      runAccess(2, 1'b1, 5'd0,  8'h11, 1'b0);
      runAccess(2, 1'b1, 5'd5,  8'h3C, 1'b0);
      runAccess(2, 1'b1, 5'd9,  8'h55, 1'b0);
      runAccess(2, 1'b0, 5'd5,  8'h00, 1'b0);

      runAccess(2, 1'b1, 5'd31, 8'hA7, 1'b0);
      checkOutput("rdata_hold_after_write", {24'd0, bus2.rdata}, 32'h3C);
      runAccess(2, 1'b0, 5'd31, 8'h00, 1'b0);
      runAccess(2, 1'b0, 5'd0,  8'h00, 1'b0);

      for (int i = 0; i < 4; i++) begin
         rnd[i] = 8'($urandom_range(0, 255));
         runAccess(2, 1'b1, 5'(10 + i), rnd[i], 1'b0);
      end
      for (int i = 3; i >= 0; i--) begin
         runAccess(2, 1'b0, 5'(10 + i), 8'h00, 1'b0);
      end

      // Both strobes: err only, no access.
      applyStimulus(2, 1'b1, 1'b1, 5'd0, 8'hEE);
      @(posedge clk);
      #1;
      applyStimulus(2, 1'b0, 1'b0, 5'd0, 8'h00);
      @(negedge clk);
      checkOutput("illegal_err",   {31'd0, bus2.err},   32'd1);
      checkOutput("illegal_busy",  {31'd0, bus2.busy},  32'd0);
      checkOutput("illegal_ready", {31'd0, bus2.ready}, 32'd0);
      @(negedge clk);
      checkOutput("illegal_err_drop", {31'd0, bus2.err},   32'd0);
      checkOutput("illegal_no_ready", {31'd0, bus2.ready}, 32'd0);
      runAccess(2, 1'b0, 5'd0, 8'h00, 1'b0);

      // Reset during the wait of a write, held across the RESP-entry edge.
      applyStimulus(2, 1'b0, 1'b1, 5'd9, 8'hFF);
      @(posedge clk);
      #1;
      applyStimulus(2, 1'b0, 1'b0, 5'd9, 8'h00);
      @(negedge clk);
      checkOutput("pre_reset_busy", {31'd0, bus2.busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("midrst_ready", {31'd0, bus2.ready}, 32'd0);
      checkOutput("midrst_busy",  {31'd0, bus2.busy},  32'd0);
      checkOutput("midrst_err",   {31'd0, bus2.err},   32'd0);
      checkOutput("midrst_rdata", {24'd0, bus2.rdata}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      runAccess(2, 1'b0, 5'd9, 8'h00, 1'b0);

`ifdef MEM_PARITY_EN
      runAccess(2, 1'b1, 5'd4, 8'h5A, 1'b0);
      runAccess(2, 1'b0, 5'd4, 8'h00, 1'b0);
      dut2.u_array.mem_q[4][8] = ~dut2.u_array.mem_q[4][8];
      runAccess(2, 1'b0, 5'd4, 8'h00, 1'b1);
`endif

      // WAIT_CYCLES=0: single-cycle latency, then a held strobe repeats every 2 cycles.
      runAccess(0, 1'b1, 5'd2, 8'h6D, 1'b0);
      begin
         exp_t e;
         logic r1, r2, r3;
         e.is_read = 1'b1;
         e.data    = model0[2];
         e.err     = 1'b0;
         sb0.push_back(e);
         sb0.push_back(e);
         applyStimulus(0, 1'b1, 1'b0, 5'd2, 8'h00);
         @(posedge clk);
         @(negedge clk);
         r1 = bus0.ready;
         @(negedge clk);
         r2 = bus0.ready;
         @(negedge clk);
         r3 = bus0.ready;
         applyStimulus(0, 1'b0, 1'b0, 5'd2, 8'h00);
         checkOutput("w0_first_ready",  {31'd0, r1}, 32'd1);
         checkOutput("w0_gap",          {31'd0, r2}, 32'd0);
         checkOutput("w0_second_ready", {31'd0, r3}, 32'd1);
         @(negedge clk);
         checkOutput("w0_quiet_ready", {31'd0, bus0.ready}, 32'd0);
         checkOutput("w0_quiet_busy",  {31'd0, bus0.busy},  32'd0);
      end

      repeat (3) @(negedge clk);
      checkOutput("sb2_drained", sb2.size(), 32'd0);
      checkOutput("sb0_drained", sb0.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
